// File: rtl/p1_pkg.sv
// Shared constants and types for the pooling-1 write stage.
package p1_pkg;
    localparam int DATA_W       = 16;
    localparam int IN_DIM       = 24;
    localparam int OUT_DIM      = IN_DIM / 2;
    localparam int ADDR_W       = 8;
    localparam int CNT_W        = $clog2(IN_DIM);
    localparam int LB_AW        = CNT_W - 1;
    localparam int P1_LAST_ADDR = OUT_DIM * OUT_DIM - 1;

    typedef logic signed [DATA_W-1:0] pixel_t;
endpackage

// File: rtl/p1_pool_write_if.sv
// Conv1 pixel stream in, P1 memory write port out.
interface p1_pool_write_if;
    import p1_pkg::*;

    logic              in_valid;
    pixel_t            in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    pixel_t            wr_data;

    modport master (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/pool_line_buf.sv
// One-row buffer of horizontal pair maxima, indexed by output column.
module pool_line_buf
    import p1_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [LB_AW-1:0] waddr,
    input  pixel_t           wdata,
    input  logic [LB_AW-1:0] raddr,
    output pixel_t           rdata
);
    pixel_t mem_q [OUT_DIM];

    // Contents need no reset: every entry is rewritten on an even row before it is read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/p1_pool_write.sv
// 2x2 stride-2 signed max-pooling of a 24x24 raster stream into a 12x12 memory image.
module p1_pool_write
    import p1_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    p1_pool_write_if.slave bus,
    output logic           done
);
    logic [CNT_W-1:0]  row_q, row_d;
    logic [CNT_W-1:0]  col_q, col_d;
    pixel_t            hmax_q, hmax_d;
    logic [ADDR_W-1:0] out_cnt_q, out_cnt_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    pixel_t            wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d;
    logic              done_q, done_d;

    logic   in_ready;
    logic   accept;
    logic   lb_we;
    pixel_t lb_rdata;
    pixel_t hpair;
    pixel_t quad;

    assign in_ready = enable && !done_q;
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        hpair = (hmax_q > bus.in_data) ? hmax_q : bus.in_data;
        quad  = (lb_rdata > hpair) ? lb_rdata : hpair;
    end

    pool_line_buf u_line_buf (
        .clk   (clk),
        .we    (lb_we),
        .waddr (col_q[CNT_W-1:1]),
        .wdata (hpair),
        .raddr (col_q[CNT_W-1:1]),
        .rdata (lb_rdata)
    );

    always_comb begin
        row_d     = row_q;
        col_d     = col_q;
        hmax_d    = hmax_q;
        out_cnt_d = out_cnt_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        lb_we     = 1'b0;
        // A strobe already in flight still finishes, so done is not gated by enable.
        done_d    = done_q || (wr_en_q && (wr_addr_q == ADDR_W'(P1_LAST_ADDR)));

        if (accept) begin
            if (!col_q[0]) begin
                hmax_d = bus.in_data;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
                wr_en_d   = 1'b1;
                wr_addr_d = out_cnt_q;
                wr_data_d = quad;
                out_cnt_d = out_cnt_q + ADDR_W'(1);
            end

            if (col_q == CNT_W'(IN_DIM - 1)) begin
                col_d = '0;
                row_d = (row_q == CNT_W'(IN_DIM - 1)) ? '0 : row_q + CNT_W'(1);
            end else begin
                col_d = col_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            row_q     <= '0;
            col_q     <= '0;
            hmax_q    <= '0;
            out_cnt_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            row_q     <= row_d;
            col_q     <= col_d;
            hmax_q    <= hmax_d;
            out_cnt_q <= out_cnt_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            done_q    <= done_d;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign done         = done_q;
endmodule

// File: doc/p1_pool_write.md
Name: p1_pool_write

Overview:
- Pooling-1 write stage: consumes the conv1 output stream for one feature map (24x24, raster order) and performs 2x2 stride-2 signed max-pooling.
- Writes the 12x12 result (144 words, addresses 0..143, row-major) into the pooling-1 output memory.
- That memory is later scanned by the P1 memory-read counter for conv2.
- Asserts done once all 144 words are written.

Parameters:
- DATA_W, 16, width of conv1 pixels and pooled outputs; two's-complement signed.
- IN_DIM, 24, input image side length in pixels; must be even.
- OUT_DIM, IN_DIM/2 (12), pooled image side; localparam, not overridable.
- ADDR_W, 8, P1 memory address width; must satisfy 2^ADDR_W >= OUT_DIM*OUT_DIM.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- enable  in  1  stage enable; when low, in_valid is ignored and all state holds.
- in_valid  in  1  a conv1 pixel is present on in_data this cycle.
- in_data  in  DATA_W  conv1 pixel, signed.
- in_ready  out  1  high when the block accepts a pixel; equals enable && !done.
- wr_en  out  1  single-cycle write strobe to P1 memory.
- wr_addr  out  ADDR_W  P1 memory write address.
- wr_data  out  DATA_W  pooled value, signed.
- done  out  1  sticky; high after the final (144th) write.

Behaviour:
- Reset (reset==0 at a clock edge) clears: wr_en=0, wr_addr=0, wr_data=0, done=0, row/col counters=0, horizontal-max register=0, line buffer contents don't-care.
- Reset mid-image discards all partial results; the next accepted pixel is treated as pixel (0,0).
- A pixel is accepted when in_valid && in_ready at a clock edge. Counters advance only on an accepted pixel. There is no backpressure beyond in_ready.
- Counters: col 0..IN_DIM-1 wraps to 0 and increments row; row 0..IN_DIM-1.
- Even row, even col: hmax <= in_data.
- Even row, odd col: linebuf[col>>1] <= max(hmax, in_data).
- Odd row, even col: hmax <= in_data.
- Odd row, odd col: next cycle drive wr_en=1, wr_data=max(linebuf[col>>1], hmax, in_data), wr_addr=out_cnt. out_cnt increments after the write.
- All comparisons are signed. Equal values may pick either operand, since the result is identical.
- Latency: wr_en is registered and rises exactly 1 cycle after the accepted odd-row/odd-col pixel. wr_en is never high on two consecutive writes unless pixels arrive back-to-back; even then each strobe lasts 1 cycle.
- wr_addr and wr_data hold their last values when wr_en=0.
- Line buffer: OUT_DIM x DATA_W registers, written only on even rows, read only on odd rows. No read/write collision within a row pair.
- Done: set in the cycle after the write to address OUT_DIM*OUT_DIM-1 (143), i.e. the same edge that drops wr_en. While done=1, in_ready=0, further in_valid is ignored, and there are no writes. done clears only on reset.
- enable dropped mid-image: counters, hmax and linebuf hold. An in-flight wr_en (registered from the prior cycle) still completes. Resuming enable continues at the same pixel position.
- in_valid gaps of any length are legal; results are independent of gap pattern.

Decomposition:
- Shared package p1_pkg:
  - DATA_W, IN_DIM, OUT_DIM, ADDR_W defaults.
  - typedef pixel_t (logic signed [DATA_W-1:0]).
  - P1_LAST_ADDR = OUT_DIM*OUT_DIM-1.
- Natural sub-module: pool_line_buf, the OUT_DIM-entry register line buffer with one write port and one combinational read port indexed by col>>1.
- The signed 3-way max stays inline.

Test Plan:
- Ramp image, in_data=row*24+col, continuous valid:
  - 144 writes; addr k=(r*12+c) carries 48r+2c+25.
  - addr0=25, addr143=575.
  - done rises 1 cycle after the addr-143 write.
- All pixels -5 except (7,10)=-2:
  - addr 3*12+5=41 gets -2; every other address gets -5, confirming signed compare.
- Ramp image with in_valid toggling 1,0,0,1,... and enable low for 10 cycles at pixel 300:
  - identical address/data sequence to the first scenario.
  - no writes while enable=0 except a pending strobe.
- Assert reset=0 for 1 cycle after pixel 100, then replay a full ramp:
  - writes start from addr 0 with data 25; no stale line-buffer data appears.
- After done, drive 50 more valid pixels:
  - in_ready=0, wr_en stays 0, done stays 1.
  - A subsequent reset clears done and wr_addr=0.
